// File: rtl/gelato_register_bank_arbiter.sv
// Banked register file with a one-read-per-bank arbiter for the operand collector.
// A request is latched in IDLE, arbitrated over the four banks in READ, and the
// resulting per-bank lanes are presented in RESP until the consumer takes them.
// Register address maps to bank = addr[1:0], row = addr[4:2]; register 0 is hardwired to 0.
module gelato_register_bank_arbiter #(
    parameter int BANK_NUM       = 4,
    parameter int SLOT_NUM       = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          req_valid,
    output logic                                          req_ready,
    input  logic [SLOT_NUM-1:0]                           req_entry_valid,
    input  logic [SLOT_NUM-1:0][1:0]                      req_collector_num,
    input  logic [SLOT_NUM-1:0][3:0][REG_ADDR_WIDTH-1:0]  req_reg_num,
    input  logic [SLOT_NUM-1:0][3:0]                      req_reg_valid,
    output logic                                          resp_valid,
    input  logic                                          resp_ready,
    output logic [BANK_NUM-1:0]                           resp_data_valid,
    output logic [BANK_NUM-1:0][1:0]                      resp_collector_index,
    output logic [BANK_NUM-1:0][1:0]                      resp_reg_index,
    output logic [BANK_NUM-1:0][DATA_WIDTH-1:0]           resp_data,
    input  logic                                          wb_valid,
    input  logic [REG_ADDR_WIDTH-1:0]                     wb_addr,
    input  logic [DATA_WIDTH-1:0]                         wb_data
);

    localparam int BANK_W  = $clog2(BANK_NUM);
    localparam int ROW_W   = REG_ADDR_WIDTH - BANK_W;
    localparam int ROW_NUM = 1 << ROW_W;

    typedef enum logic [1:0] {IDLE, READ, RESP} state_t;

    state_t state_q;
    logic   req_ready_q;
    logic   resp_valid_q;

    // Latched copy of the accepted request; arbitration works only from these.
    logic [SLOT_NUM-1:0]                          entry_valid_q;
    logic [SLOT_NUM-1:0][1:0]                     collector_q;
    logic [SLOT_NUM-1:0][3:0][REG_ADDR_WIDTH-1:0] reg_num_q;
    logic [SLOT_NUM-1:0][3:0]                     reg_valid_q;

    logic [BANK_NUM-1:0]                 lane_valid_q, lane_valid_d;
    logic [BANK_NUM-1:0][1:0]            lane_coll_q,  lane_coll_d;
    logic [BANK_NUM-1:0][1:0]            lane_idx_q,   lane_idx_d;
    logic [BANK_NUM-1:0][DATA_WIDTH-1:0] lane_data_q,  lane_data_d;

    // Banks need a full clear on reset, so they live in flops rather than RAM.
    logic [DATA_WIDTH-1:0] mem_q [BANK_NUM][ROW_NUM];

    logic              wb_en;
    logic [BANK_W-1:0] wb_bank;
    logic [ROW_W-1:0]  wb_row;

    // Writes to register 0 are dropped so that it always reads as zero.
    assign wb_en   = wb_valid && (wb_addr != '0);
    assign wb_bank = wb_addr[BANK_W-1:0];
    assign wb_row  = wb_addr[REG_ADDR_WIDTH-1:BANK_W];

    // Writeback port: accepted in every state, independent of the arbiter FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < BANK_NUM; b++) begin
                for (int r = 0; r < ROW_NUM; r++) begin
                    mem_q[b][r] <= '0;
                end
            end
        end else if (wb_en) begin
            mem_q[wb_bank][wb_row] <= wb_data;
        end
    end

    // Per bank, grant the lowest k = slot*3 + (op-1) live candidate; a same-bank write kills the lane.
    always_comb begin
        lane_valid_d = '0;
        lane_coll_d  = '0;
        lane_idx_d   = '0;
        lane_data_d  = '0;
        for (int b = 0; b < BANK_NUM; b++) begin
            for (int s = 0; s < SLOT_NUM; s++) begin
                // Operand index 0 is never a candidate; slots then ops ascending gives increasing k.
                for (int op = 0; op < 4; op++) begin
                    if (op != 0 && entry_valid_q[s] && reg_valid_q[s][op] &&
                        reg_num_q[s][op][BANK_W-1:0] == BANK_W'(b) && !lane_valid_d[b]) begin
                        lane_valid_d[b] = 1'b1;
                        lane_coll_d[b]  = collector_q[s];
                        lane_idx_d[b]   = 2'(op);
                        lane_data_d[b]  = mem_q[b][reg_num_q[s][op][REG_ADDR_WIDTH-1:BANK_W]];
                    end
                end
            end
            if (wb_en && wb_bank == BANK_W'(b)) begin
                lane_valid_d[b] = 1'b0;
                lane_coll_d[b]  = '0;
                lane_idx_d[b]   = '0;
                lane_data_d[b]  = '0;
            end
        end
    end

    // Request/response FSM with registered handshake and lane outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            req_ready_q   <= 1'b0;
            resp_valid_q  <= 1'b0;
            entry_valid_q <= '0;
            collector_q   <= '0;
            reg_num_q     <= '0;
            reg_valid_q   <= '0;
            lane_valid_q  <= '0;
            lane_coll_q   <= '0;
            lane_idx_q    <= '0;
            lane_data_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid && req_ready_q) begin
                        entry_valid_q <= req_entry_valid;
                        collector_q   <= req_collector_num;
                        reg_num_q     <= req_reg_num;
                        reg_valid_q   <= req_reg_valid;
                        req_ready_q   <= 1'b0;
                        state_q       <= READ;
                    end else begin
                        req_ready_q   <= 1'b1;
                    end
                end
                READ: begin
                    lane_valid_q <= lane_valid_d;
                    lane_coll_q  <= lane_coll_d;
                    lane_idx_q   <= lane_idx_d;
                    lane_data_q  <= lane_data_d;
                    resp_valid_q <= 1'b1;
                    state_q      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        lane_valid_q <= '0;
                        lane_coll_q  <= '0;
                        lane_idx_q   <= '0;
                        lane_data_q  <= '0;
                        req_ready_q  <= 1'b1;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready            = req_ready_q;
    assign resp_valid           = resp_valid_q;
    assign resp_data_valid      = lane_valid_q;
    assign resp_collector_index = lane_coll_q;
    assign resp_reg_index       = lane_idx_q;
    assign resp_data            = lane_data_q;

endmodule

// File: tb/tb_gelato_register_bank_arbiter.sv
// Directed bench for gelato_register_bank_arbiter: writeback, per-bank arbitration,
// write/read conflict, response back-pressure and asynchronous reset.
module tb_gelato_register_bank_arbiter;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic [3:0]        req_entry_valid;
    logic [3:0][1:0]   req_collector_num;
    logic [3:0][3:0][4:0] req_reg_num;
    logic [3:0][3:0]   req_reg_valid;
    logic              resp_valid;
    logic              resp_ready;
    logic [3:0]        resp_data_valid;
    logic [3:0][1:0]   resp_collector_index;
    logic [3:0][1:0]   resp_reg_index;
    logic [3:0][31:0]  resp_data;
    logic              wb_valid;
    logic [4:0]        wb_addr;
    logic [31:0]       wb_data;

    int checks = 0;
    int errors = 0;

    gelato_register_bank_arbiter dut (
        .clk                  (clk),
        .rst                  (rst),
        .req_valid            (req_valid),
        .req_ready            (req_ready),
        .req_entry_valid      (req_entry_valid),
        .req_collector_num    (req_collector_num),
        .req_reg_num          (req_reg_num),
        .req_reg_valid        (req_reg_valid),
        .resp_valid           (resp_valid),
        .resp_ready           (resp_ready),
        .resp_data_valid      (resp_data_valid),
        .resp_collector_index (resp_collector_index),
        .resp_reg_index       (resp_reg_index),
        .resp_data            (resp_data),
        .wb_valid             (wb_valid),
        .wb_addr              (wb_addr),
        .wb_data              (wb_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Slot collector numbers: slot0=3, slot1=1, slot2=2, slot3=0.
    task automatic clear_req();
        req_entry_valid   = '0;
        req_collector_num = {2'd0, 2'd2, 2'd1, 2'd3};
        req_reg_num       = '0;
        req_reg_valid     = '0;
    endtask

    task automatic set_op(input int slot, input int op, input logic [4:0] r);
        req_entry_valid[slot]    = 1'b1;
        req_reg_valid[slot][op]  = 1'b1;
        req_reg_num[slot][op]    = r;
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        wb_valid = 1'b1;
        wb_addr  = a;
        wb_data  = d;
        @(negedge clk);
        wb_valid = 1'b0;
        $display("wb      addr=%0d data=%h", a, d);
    endtask

    // Called in an IDLE cycle at a negedge; returns at the negedge inside RESP.
    task automatic do_req(input bit wb_en, input logic [4:0] a, input logic [31:0] d);
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check("ready_in_read", 128'(req_ready), 128'(1'b0));
        if (wb_en) begin
            wb_valid = 1'b1;
            wb_addr  = a;
            wb_data  = d;
        end
        @(negedge clk);
        wb_valid = 1'b0;
        $display("resp    valid=%0b lanes=%b coll=%h idx=%h data=%h",
                 resp_valid, resp_data_valid, resp_collector_index, resp_reg_index, resp_data);
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        wb_valid   = 1'b0;
        wb_addr    = '0;
        wb_data    = '0;
        clear_req();

        // Reset values
        #12;
        check("rst_req_ready",  128'(req_ready),       128'(1'b0));
        check("rst_resp_valid", 128'(resp_valid),      128'(1'b0));
        check("rst_data_valid", 128'(resp_data_valid), 128'(4'b0));
        check("rst_coll",       128'(resp_collector_index), 128'(8'h0));
        check("rst_idx",        128'(resp_reg_index),  128'(8'h0));
        check("rst_data",       128'(resp_data),       128'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 128'(req_ready), 128'(1'b1));

        // Single read of reg 5 (bank 1, row 1)
        wb_write(5'd5, 32'hA5);
        set_op(0, 1, 5'd5);
        do_req(1'b0, 5'd0, 32'h0);
        check("t1_resp_valid", 128'(resp_valid),      128'(1'b1));
        check("t1_lanes",      128'(resp_data_valid), 128'(4'b0010));
        check("t1_data",       128'(resp_data),       128'({32'h0, 32'h0, 32'hA5, 32'h0}));
        check("t1_coll",       128'(resp_collector_index), 128'(8'h0C));
        check("t1_idx",        128'(resp_reg_index),  128'(8'h04));
        @(negedge clk);
        check("t1_after_valid", 128'(resp_valid), 128'(1'b0));
        check("t1_after_ready", 128'(req_ready),  128'(1'b1));

        // Three operands on bank 0: only lowest k is served
        wb_write(5'd4,  32'h44);
        wb_write(5'd8,  32'h88);
        wb_write(5'd12, 32'hCC);
        clear_req();
        set_op(0, 1, 5'd4);
        set_op(0, 2, 5'd8);
        set_op(0, 3, 5'd12);
        do_req(1'b0, 5'd0, 32'h0);
        check("t2a_lanes", 128'(resp_data_valid), 128'(4'b0001));
        check("t2a_data",  128'(resp_data),       128'({32'h0, 32'h0, 32'h0, 32'h44}));
        check("t2a_idx",   128'(resp_reg_index),  128'(8'h01));
        check("t2a_coll",  128'(resp_collector_index), 128'(8'h03));
        @(negedge clk);
        clear_req();
        set_op(0, 2, 5'd8);
        set_op(0, 3, 5'd12);
        do_req(1'b0, 5'd0, 32'h0);
        check("t2b_lanes", 128'(resp_data_valid), 128'(4'b0001));
        check("t2b_data",  128'(resp_data),       128'({32'h0, 32'h0, 32'h0, 32'h88}));
        check("t2b_idx",   128'(resp_reg_index),  128'(8'h02));
        @(negedge clk);

        // Four distinct banks served in one response
        wb_write(5'd1, 32'h11);
        wb_write(5'd2, 32'h22);
        wb_write(5'd3, 32'h33);
        clear_req();
        set_op(0, 1, 5'd1);
        set_op(0, 2, 5'd2);
        set_op(0, 3, 5'd3);
        set_op(1, 1, 5'd4);
        do_req(1'b0, 5'd0, 32'h0);
        check("t3_lanes", 128'(resp_data_valid), 128'(4'b1111));
        check("t3_data",  128'(resp_data),       128'({32'h33, 32'h22, 32'h11, 32'h44}));
        check("t3_coll",  128'(resp_collector_index), 128'(8'hFD));
        check("t3_idx",   128'(resp_reg_index),  128'(8'hE5));
        @(negedge clk);

        // Same-bank writeback during READ kills the lane; next request sees new data
        wb_write(5'd6, 32'h66);
        clear_req();
        set_op(0, 1, 5'd6);
        do_req(1'b1, 5'd6, 32'h77);
        check("t4a_valid", 128'(resp_valid),      128'(1'b1));
        check("t4a_lanes", 128'(resp_data_valid), 128'(4'b0000));
        check("t4a_data",  128'(resp_data),       128'(0));
        @(negedge clk);
        do_req(1'b0, 5'd0, 32'h0);
        check("t4b_lanes", 128'(resp_data_valid), 128'(4'b0100));
        check("t4b_data",  128'(resp_data),       128'({32'h0, 32'h77, 32'h0, 32'h0}));
        check("t4b_idx",   128'(resp_reg_index),  128'(8'h10));
        @(negedge clk);

        // Other-bank writeback during READ: lane survives with old data, write lands
        clear_req();
        set_op(0, 1, 5'd5);
        do_req(1'b1, 5'd2, 32'h2F);
        check("t5a_lanes", 128'(resp_data_valid), 128'(4'b0010));
        check("t5a_data",  128'(resp_data),       128'({32'h0, 32'h0, 32'hA5, 32'h0}));
        @(negedge clk);
        clear_req();
        set_op(0, 1, 5'd2);
        do_req(1'b0, 5'd0, 32'h0);
        check("t5b_lanes", 128'(resp_data_valid), 128'(4'b0100));
        check("t5b_data",  128'(resp_data),       128'({32'h0, 32'h2F, 32'h0, 32'h0}));
        @(negedge clk);

        // No live entries, response held under back-pressure
        clear_req();
        req_reg_valid[0][1] = 1'b1;
        req_reg_num[0][1]   = 5'd5;
        resp_ready = 1'b0;
        do_req(1'b0, 5'd0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            check("t6_hold_valid", 128'(resp_valid),      128'(1'b1));
            check("t6_hold_ready", 128'(req_ready),       128'(1'b0));
            check("t6_hold_lanes", 128'(resp_data_valid), 128'(4'b0000));
            check("t6_hold_data",  128'(resp_data),       128'(0));
            $display("hold    cycle=%0d valid=%0b ready=%0b", i, resp_valid, req_ready);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        check("t6_last_valid", 128'(resp_valid), 128'(1'b1));
        @(negedge clk);
        check("t6_done_valid", 128'(resp_valid), 128'(1'b0));
        check("t6_done_ready", 128'(req_ready),  128'(1'b1));

        // Asynchronous reset while in RESP
        clear_req();
        set_op(0, 1, 5'd5);
        do_req(1'b0, 5'd0, 32'h0);
        check("t7_pre_valid", 128'(resp_valid), 128'(1'b1));
        rst = 1'b1;
        #1;
        check("t7_rst_valid", 128'(resp_valid),      128'(1'b0));
        check("t7_rst_lanes", 128'(resp_data_valid), 128'(4'b0000));
        check("t7_rst_data",  128'(resp_data),       128'(0));
        check("t7_rst_ready", 128'(req_ready),       128'(1'b0));
        $display("reset   asserted in RESP");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t7_ready", 128'(req_ready), 128'(1'b1));
        clear_req();
        set_op(0, 1, 5'd1);
        do_req(1'b0, 5'd0, 32'h0);
        check("t7_r1_lanes", 128'(resp_data_valid), 128'(4'b0010));
        check("t7_r1_data",  128'(resp_data),       128'(0));
        @(negedge clk);

        // Register 0: writes are dropped and never conflict
        wb_write(5'd0, 32'hDEAD);
        clear_req();
        set_op(0, 1, 5'd0);
        do_req(1'b1, 5'd0, 32'hBEEF);
        check("t8_lanes", 128'(resp_data_valid), 128'(4'b0001));
        check("t8_data",  128'(resp_data),       128'(0));
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
